// File: rtl/sequenciador_sel.sv
// sequenciador_sel: issues the sel command sequence for the X/Y/Z/ULA datapath.
// Moore FSM plus a shift down-counter, with start/ready/done handshake upstream.
module sequenciador_sel #(
  parameter int          CW      = 4,
  parameter logic [3:0]  SEL_NOP = 4'b0101
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [CW-1:0] n_desl,
  input  logic          cancela,
  output logic [3:0]    sel,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [3:0] SEL_CARGA_X  = 4'b0000;
  localparam logic [3:0] SEL_CARGA_XY = 4'b0001;
  localparam logic [3:0] SEL_CARGA_Y  = 4'b0010;
  localparam logic [3:0] SEL_DESL_Y   = 4'b0011;
  localparam logic [3:0] SEL_RESULT_Z = 4'b0100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CARGA,
    S_CARGA_XY,
    S_CARGA_Y,
    S_DESLOCA,
    S_RESULT,
    S_FIM
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          err_nx;
  logic [3:0]    sel_nx;

  // Next-state, counter and illegal-op detection
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    err_nx   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          unique case (op)
            2'b00: state_nx = S_CARGA;
            2'b01: state_nx = S_CARGA_XY;
            2'b10: begin
              state_nx = S_CARGA_Y;
              cnt_nx   = n_desl;
            end
            default: err_nx = 1'b1;
          endcase
        end
      end
      S_CARGA:    state_nx = S_FIM;
      S_CARGA_XY: state_nx = S_RESULT;
      S_CARGA_Y: begin
        if (cnt != '0) state_nx = S_DESLOCA;
        else           state_nx = S_RESULT;
      end
      S_DESLOCA: begin
        if (cnt != '0) cnt_nx = cnt - 1'b1;
        // cnt==0 cannot occur here; leaving anyway keeps the FSM from sticking
        if (cnt == CW'(1) || cnt == '0) state_nx = S_RESULT;
      end
      S_RESULT: state_nx = S_FIM;
      S_FIM:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    if (cancela && state != S_IDLE) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      err_nx   = 1'b0;
    end
  end

  // Sel code belonging to the upcoming state, so sel comes straight from a flop
  always_comb begin
    sel_nx = SEL_NOP;
    unique case (state_nx)
      S_CARGA:    sel_nx = SEL_CARGA_X;
      S_CARGA_XY: sel_nx = SEL_CARGA_XY;
      S_CARGA_Y:  sel_nx = SEL_CARGA_Y;
      S_DESLOCA:  sel_nx = SEL_DESL_Y;
      S_RESULT:   sel_nx = SEL_RESULT_Z;
      default:    sel_nx = SEL_NOP;
    endcase
  end

  // State, counter, sel and err registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      sel   <= SEL_NOP;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      sel   <= sel_nx;
      err   <= err_nx;
    end
  end

  assign ready = (state == S_IDLE);
  assign busy  = ~ready;
  assign done  = (state == S_FIM);

endmodule

// File: tb/tb_sequenciador_sel.sv
// tb_sequenciador_sel: table-driven commands with a per-cycle expectation queue,
// plus hand sequences for reset, cancel and back-to-back starts.
module tb_sequenciador_sel;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [3:0] n_desl;
  logic       cancela;
  logic [3:0] sel;
  logic       ready, busy, done, err;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] NOP = 4'b0101;

  typedef struct {
    logic [1:0] op;
    logic [3:0] n;
    int         lat;
    string      name;
  } vec_t;

  logic [7:0] q[$];

  sequenciador_sel dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .n_desl(n_desl),
    .cancela(cancela), .sel(sel), .ready(ready), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rec(input logic [3:0] s, input logic r,
                                     input logic b, input logic d, input logic e);
    return {s, r, b, d, e};
  endfunction

  function automatic logic [7:0] obs();
    return {sel, ready, busy, done, err};
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (sel/ready/busy/done/err)", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push the cycle-by-cycle outputs a command must produce, then check them
  task automatic run_cmd(input logic [1:0] o, input logic [3:0] n,
                         input int lat, input string nm);
    int cyc;
    int got_lat;
    logic [7:0] e;
    start  = 1'b1;
    op     = o;
    n_desl = n;
    case (o)
      2'd0: q.push_back(rec(4'b0000, 0, 1, 0, 0));
      2'd1: begin
        q.push_back(rec(4'b0001, 0, 1, 0, 0));
        q.push_back(rec(4'b0100, 0, 1, 0, 0));
      end
      2'd2: begin
        q.push_back(rec(4'b0010, 0, 1, 0, 0));
        for (int i = 0; i < int'(n); i++) q.push_back(rec(4'b0011, 0, 1, 0, 0));
        q.push_back(rec(4'b0100, 0, 1, 0, 0));
      end
      default: q.push_back(rec(NOP, 1, 0, 0, 1));
    endcase
    if (o != 2'd3) q.push_back(rec(NOP, 0, 1, 1, 0));
    q.push_back(rec(NOP, 1, 0, 0, 0));
    cyc = 0;
    got_lat = -1;
    while (q.size() > 0) begin
      tick();
      start  = 1'b0;
      op     = 2'($urandom);
      n_desl = 4'($urandom);
      cyc++;
      e = q.pop_front();
      chk($sformatf("%s_c%0d", nm, cyc), obs(), e);
      if (done && got_lat < 0) got_lat = cyc;
    end
    chk({nm, "_lat"}, got_lat, lat);
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1; start = 0; op = 0; n_desl = 0; cancela = 0;
    tbl = '{
      '{2'd0, 4'd0,  2, "carga"},
      '{2'd1, 4'd0,  3, "opera"},
      '{2'd2, 4'd3,  6, "desl3"},
      '{2'd2, 4'd0,  3, "desl0"},
      '{2'd2, 4'd1,  4, "desl1"},
      '{2'd2, 4'd15, 18, "desl15"},
      '{2'd3, 4'd0, -1, "ilegal"},
      '{2'd1, 4'd7,  3, "opera2"}
    };
    tick();
    tick();
    chk("reset_state", obs(), rec(NOP, 1, 0, 0, 0));
    rst = 1'b0;

    foreach (tbl[i]) run_cmd(tbl[i].op, tbl[i].n, tbl[i].lat, tbl[i].name);

    // Async reset in the middle of DESLOCA
    start = 1; op = 2'd2; n_desl = 4'd5;
    tick();
    start = 0;
    chk("rst_pre_cy", obs(), rec(4'b0010, 0, 1, 0, 0));
    tick();
    chk("rst_pre_dy", obs(), rec(4'b0011, 0, 1, 0, 0));
    #2 rst = 1'b1;
    #1 chk("rst_async", obs(), rec(NOP, 1, 0, 0, 0));
    tick();
    rst = 1'b0;
    run_cmd(2'd0, 4'd0, 2, "rst_carga");

    // Cancel during the second DESL_Y of n_desl=5
    start = 1; op = 2'd2; n_desl = 4'd5;
    tick();
    start = 0;
    chk("can_cy", obs(), rec(4'b0010, 0, 1, 0, 0));
    tick();
    chk("can_dy1", obs(), rec(4'b0011, 0, 1, 0, 0));
    tick();
    chk("can_dy2", obs(), rec(4'b0011, 0, 1, 0, 0));
    cancela = 1;
    tick();
    cancela = 0;
    chk("can_idle", obs(), rec(NOP, 1, 0, 0, 0));
    run_cmd(2'd1, 4'd0, 3, "after_can");

    // start and cancela together in IDLE: start wins; cancela in FIM keeps done
    start = 1; op = 2'd0; cancela = 1;
    tick();
    start = 0; cancela = 0;
    chk("sc_carga", obs(), rec(4'b0000, 0, 1, 0, 0));
    tick();
    chk("sc_fim", obs(), rec(NOP, 0, 1, 1, 0));
    cancela = 1;
    tick();
    cancela = 0;
    chk("sc_idle", obs(), rec(NOP, 1, 0, 0, 0));

    // cancela alone in IDLE has no effect
    cancela = 1;
    tick();
    cancela = 0;
    chk("can_in_idle", obs(), rec(NOP, 1, 0, 0, 0));

    // start held high: back-to-back OPERA, only restarted from IDLE
    start = 1; op = 2'd1;
    for (int k = 0; k < 12; k++) begin
      case (k % 4)
        0: q.push_back(rec(4'b0001, 0, 1, 0, 0));
        1: q.push_back(rec(4'b0100, 0, 1, 0, 0));
        2: q.push_back(rec(NOP, 0, 1, 1, 0));
        default: q.push_back(rec(NOP, 1, 0, 0, 0));
      endcase
    end
    for (int k = 0; k < 12; k++) begin
      logic [7:0] e;
      tick();
      e = q.pop_front();
      chk($sformatf("b2b_c%0d", k), obs(), e);
    end
    start = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
